// File: rtl/fetch_cycle.sv
// IF stage and IF/ID pipeline register for the 5-stage RV32I core.
// Next-PC prediction uses a direct-mapped BHT of 2-bit counters and a tagged BTB, trained from execute.
module fetch_cycle #(
  parameter int          INDEX_BITS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        Predict_branchD,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        MispredictE,
  input  logic [31:0] PCRedirectE
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [TAG_BITS-1:0] tagArr    [ENTRIES];
  logic [31:0]         targetArr [ENTRIES];
  logic [1:0]          ctrArr    [ENTRIES];
  logic [ENTRIES-1:0]  validArr;

  logic [INDEX_BITS-1:0] fIdx;
  logic [INDEX_BITS-1:0] eIdx;
  logic [TAG_BITS-1:0]   fTag;
  logic [TAG_BITS-1:0]   eTag;
  logic                  fHit;
  logic                  eHit;
  logic                  predT;
  logic [31:0]           pcPlus4F;
  logic [31:0]           predPC;
  logic [1:0]            ctrNext;

  assign fIdx = PCF[INDEX_BITS+1:2];
  assign fTag = PCF[31:INDEX_BITS+2];
  assign eIdx = PCE[INDEX_BITS+1:2];
  assign eTag = PCE[31:INDEX_BITS+2];

  // Lookup reads the arrays as they stood before this edge; there is no bypass from training.
  always_comb begin
    fHit     = validArr[fIdx] && (tagArr[fIdx] == fTag);
    predT    = fHit && ctrArr[fIdx][1];
    pcPlus4F = PCF + 32'd4;
    predPC   = predT ? targetArr[fIdx] : pcPlus4F;
  end

  always_comb begin
    eHit    = validArr[eIdx] && (tagArr[eIdx] == eTag);
    ctrNext = ctrArr[eIdx];
    if (TakenE) begin
      if (ctrNext != 2'b11) ctrNext = ctrNext + 2'd1;
    end else begin
      if (ctrNext != 2'b00) ctrNext = ctrNext - 2'd1;
    end
  end

  // A redirect from execute wins over a fetch stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCF <= RESET_PC;
    end else if (MispredictE) begin
      PCF <= PCRedirectE;
    end else if (!StallF) begin
      PCF <= predPC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD          <= 32'd0;
      PCD             <= 32'd0;
      PCPlus4D        <= 32'd0;
      Predict_branchD <= 1'b0;
    end else if (FlushD) begin
      InstrD          <= 32'd0;
      PCD             <= 32'd0;
      PCPlus4D        <= 32'd0;
      Predict_branchD <= 1'b0;
    end else if (!StallD) begin
      InstrD          <= InstrF;
      PCD             <= PCF;
      PCPlus4D        <= pcPlus4F;
      Predict_branchD <= predT;
    end
  end

  // Counters and valid bits; a taken miss allocates weakly-taken, a not-taken miss is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validArr <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrArr[i] <= 2'b01;
    end else if (BranchE) begin
      if (eHit) begin
        ctrArr[eIdx] <= ctrNext;
      end else if (TakenE) begin
        validArr[eIdx] <= 1'b1;
        ctrArr[eIdx]   <= 2'b10;
      end
    end
  end

  // Tag and target need no reset since validArr gates every use of them.
  always_ff @(posedge clk) begin
    if (rst && BranchE && TakenE) begin
      tagArr[eIdx]    <= eTag;
      targetArr[eIdx] <= PCTargetE;
    end
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed, table-driven bench for fetch_cycle; the imem returns ~PC so InstrD is predictable.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        Predict_branchD;
  logic        BranchE, TakenE, MispredictE;
  logic [31:0] PCE, PCTargetE, PCRedirectE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stallF, stallD, flushD, misp;
    logic [31:0] redir;
    logic        brE, takE;
    logic [31:0] pcE, tgtE;
    logic [31:0] expPCF, expPCD;
    logic        expPred, expBub;
  } vec_t;

  vec_t vecs[$];

  fetch_cycle #(.INDEX_BITS(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Predict_branchD(Predict_branchD), .BranchE(BranchE), .TakenE(TakenE),
    .PCE(PCE), .PCTargetE(PCTargetE), .MispredictE(MispredictE), .PCRedirectE(PCRedirectE)
  );

  always #5 clk = ~clk;
  assign InstrF = ~PCF;

  task automatic addVec(input logic sF, input logic sD, input logic fD, input logic mis,
                        input logic [31:0] redir, input logic br, input logic tk,
                        input logic [31:0] pcE, input logic [31:0] tgt,
                        input logic [31:0] ePCF, input logic [31:0] ePCD,
                        input logic ePred, input logic eBub);
    vec_t v;
    v.stallF = sF; v.stallD = sD; v.flushD = fD; v.misp = mis; v.redir = redir;
    v.brE = br; v.takE = tk; v.pcE = pcE; v.tgtE = tgt;
    v.expPCF = ePCF; v.expPCD = ePCD; v.expPred = ePred; v.expBub = eBub;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    StallF = v.stallF; StallD = v.stallD; FlushD = v.flushD;
    MispredictE = v.misp; PCRedirectE = v.redir;
    BranchE = v.brE; TakenE = v.takE; PCE = v.pcE; PCTargetE = v.tgtE;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic runVec(input int i);
    vec_t v;
    logic [31:0] expInstr, expPlus4;
    v = vecs[i];
    applyStimulus(v);
    @(posedge clk);
    #1;
    expInstr = v.expBub ? 32'd0 : ~v.expPCD;
    expPlus4 = v.expBub ? 32'd0 : v.expPCD + 32'd4;
    checkOutput("PCF", i, PCF, v.expPCF);
    checkOutput("PCD", i, PCD, v.expPCD);
    checkOutput("InstrD", i, InstrD, expInstr);
    checkOutput("PCPlus4D", i, PCPlus4D, expPlus4);
    checkOutput("Predict_branchD", i, {31'd0, Predict_branchD}, {31'd0, v.expPred});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //     sF sD fD mis redir          br tk pcE           tgt           ePCF           ePCD          pr bub
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h04,        32'h00,        0, 0); // 0
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h08,        32'h04,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h0C,        32'h08,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h10,        32'h0C,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 1, 32'h20, 32'h80,  32'h14,        32'h10,        0, 0); // allocate 0x20
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h18,        32'h14,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h1C,        32'h18,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h20,        32'h1C,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h80,        32'h20,        1, 0); // predicted jump
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h84,        32'h80,        0, 0);
    addVec(1, 0, 0, 1, 32'h20,        0, 0, 32'h0,  32'h0,   32'h20,        32'h84,        0, 0); // 10 redirect beats stall
    addVec(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h20,        32'h20,        1, 0);
    addVec(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h20,        32'h20,        1, 0);
    addVec(1, 0, 1, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h20,        32'h00,        0, 1); // flush
    addVec(1, 0, 0, 0, 32'h0,         1, 1, 32'h20, 32'h80,  32'h20,        32'h20,        1, 0); // ctr 11
    addVec(1, 0, 0, 0, 32'h0,         1, 1, 32'h20, 32'h80,  32'h20,        32'h20,        1, 0); // ctr stays 11
    addVec(1, 0, 0, 0, 32'h0,         1, 0, 32'h20, 32'h0,   32'h20,        32'h20,        1, 0); // ctr 10
    addVec(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h20,        32'h20,        1, 0);
    addVec(1, 0, 0, 0, 32'h0,         1, 0, 32'h20, 32'h0,   32'h20,        32'h20,        1, 0); // ctr 01
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h24,        32'h20,        0, 0);
    addVec(0, 0, 0, 1, 32'h20,        1, 1, 32'h20, 32'h80,  32'h20,        32'h24,        0, 0); // 20 ctr 10
    addVec(1, 0, 0, 0, 32'h0,         1, 0, 32'h60, 32'h0,   32'h20,        32'h20,        1, 0); // alias not-taken
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h80,        32'h20,        1, 0);
    addVec(0, 0, 0, 1, 32'h20,        1, 1, 32'h60, 32'h200, 32'h20,        32'h80,        0, 0); // alias evicts
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h24,        32'h20,        0, 0);
    addVec(0, 0, 0, 1, 32'h20,        0, 0, 32'h0,  32'h0,   32'h20,        32'h24,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 1, 32'h20, 32'h80,  32'h24,        32'h20,        0, 0); // no bypass
    addVec(0, 0, 0, 1, 32'h20,        0, 0, 32'h0,  32'h0,   32'h20,        32'h24,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h80,        32'h20,        1, 0);
    addVec(0, 0, 0, 1, 32'hFFFFFFFC,  0, 0, 32'h0,  32'h0,   32'hFFFFFFFC,  32'h80,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h00,        32'hFFFFFFFC,  0, 0); // 30 wrap
    addVec(0, 1, 1, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h04,        32'h00,        0, 1); // flush beats stall
    addVec(0, 0, 0, 1, 32'h22,        0, 0, 32'h0,  32'h0,   32'h22,        32'h04,        0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h80,        32'h22,        1, 0); // PC[1:0] ignored
    addVec(0, 0, 0, 1, 32'h20,        0, 0, 32'h0,  32'h0,   32'h20,        32'h00,        0, 0); // after mid-run reset
    addVec(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  32'h0,   32'h24,        32'h20,        0, 0); // predictor cleared

    rst = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; MispredictE = 0; PCRedirectE = '0;
    BranchE = 0; TakenE = 0; PCE = '0; PCTargetE = '0;
    #12;
    checkOutput("reset PCF", -1, PCF, 32'h0);
    checkOutput("reset PCD", -1, PCD, 32'h0);
    checkOutput("reset InstrD", -1, InstrD, 32'h0);
    checkOutput("reset Predict_branchD", -1, {31'd0, Predict_branchD}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 34; i++) runVec(i);

    applyStimulus(vecs[0]);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async reset PCF", -2, PCF, 32'h0);
    checkOutput("async reset PCD", -2, PCD, 32'h0);
    checkOutput("async reset InstrD", -2, InstrD, 32'h0);
    checkOutput("async reset PCPlus4D", -2, PCPlus4D, 32'h0);
    checkOutput("async reset Predict_branchD", -2, {31'd0, Predict_branchD}, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    for (int i = 34; i < vecs.size(); i++) runVec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I core; directly feeds the decode stage (InstrD, PCD, PCPlus4D, Predict_branchD).
- Holds the PC and a direct-mapped branch predictor: BHT of 2-bit saturating counters plus a tagged BTB.
- Predicts next PC every cycle, is trained by resolved branches from execute, and is redirected on a mispredict.

Parameters:
- INDEX_BITS, 4, log2 of BHT/BTB entries (16 entries); index = PC[INDEX_BITS+1:2].
- RESET_PC, 32'h0000_0000, PCF value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- StallF  input  1  hold PCF (hazard unit).
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  bubble IF/ID register.
- InstrF  input  32  instruction read from imem at PCF (combinational imem).
- PCF  output  32  current fetch address to imem.
- InstrD  output  32  registered instruction to decode.
- PCD  output  32  registered PC of InstrD.
- PCPlus4D  output  32  registered PC+4.
- Predict_branchD  output  1  registered taken prediction made for InstrD.
- BranchE  input  1  execute holds a resolved conditional branch; train predictor.
- TakenE  input  1  actual outcome of that branch.
- PCE  input  32  PC of the resolved branch.
- PCTargetE  input  32  computed branch target.
- MispredictE  input  1  redirect request from execute.
- PCRedirectE  input  32  correct next PC when MispredictE=1.

Behaviour:
- Reset (rst=0, async): PCF=RESET_PC; InstrD, PCD, PCPlus4D=0; Predict_branchD=0; all BTB valid=0; all counters=2'b01 (weakly not-taken). Tags and targets are don't-care.
- Lookup (combinational on PCF):
  - idx = PCF[INDEX_BITS+1:2]; tag = PCF[31:INDEX_BITS+2].
  - hit = valid[idx] && tag[idx]==tag.
  - predT = hit && ctr[idx][1].
  - predPC = predT ? target[idx] : PCF+4.
- Next PCF, priority order:
  1. MispredictE → PCRedirectE.
  2. else StallF → hold.
  3. else predPC.
- Mispredict overrides StallF.
- IF/ID register, priority order:
  1. rst.
  2. FlushD → all outputs 0 (bubble, Predict_branchD=0).
  3. StallD → hold.
  4. else load InstrF, PCF, PCF+4, predT.
- Latency: an instruction appears on InstrD one clock after its PCF. Correct fetch resumes the cycle after MispredictE. The hazard unit asserts FlushD/FlushE for wrong-path instructions; this block does not self-flush.
- Training on BranchE, using eidx/etag from PCE:
  - tag hit: ctr saturating +1 if TakenE, else -1 (limits 00/11). If TakenE, target ← PCTargetE.
  - tag miss, TakenE=1: allocate. valid=1, tag=etag, target=PCTargetE, ctr=2'b10.
  - tag miss, TakenE=0: no change.
- Write/read ordering: predictor arrays update at the clock edge. A same-cycle lookup of the same index sees the pre-update contents (no bypass).
- Training happens regardless of StallF/StallD/FlushD. Training is blocked only by reset.
- Aliasing: a different PC with the same index and a different tag misses and is never predicted taken. A taken alias evicts the entry.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC+4 → 0). PC[1:0] is ignored for indexing.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
- Reset then run 4 cycles with no branches → PCF 0,4,8,12. PCD lags by one. Predict_branchD=0. Release of rst=0 mid-run returns PCF to 0 asynchronously.
- BranchE=1, TakenE=1, PCE=0x20, PCTargetE=0x80 → when PCF later reaches 0x20, next PCF=0x80 and Predict_branchD=1 with PCD=0x20.
- Train PC 0x20 taken ×3 (ctr=11), then not-taken ×1 → still predicted taken. A second not-taken → ctr=01 and next PCF after 0x20 is 0x24.
- MispredictE=1, PCRedirectE=0x100 with StallF=1 in the same cycle → PCF=0x100 next cycle. StallF=1 alone holds PCF. StallD=1 holds InstrD. FlushD=1 zeroes InstrD, PCD and Predict_branchD.
- Alias: allocate 0x20 taken, then PC 0x60 (same index, INDEX_BITS=4) not-taken → 0x20 is still predicted. Then 0x60 taken → 0x20 misses and predicts 0x24.
- Lookup of PCF=0x20 in the same cycle as its first taken training → that cycle predicts not-taken. The following visit predicts taken.
